watch_time_setter: RTL and testbench
====================================

// Module: watch_time_setter
// PURPOSE
//  Time-setting controller: the writer side of the watch counter chain. On setTime,
//  snapshots the running BCD time and freezes the watch. The user steps hours, minutes
//  and seconds with inc/dec pulses, then commits via a one-cycle load strobe carrying
//  the new digits. Sits between debounced buttons and the watch counter chain.
// PARAMETERS
//  HOUR_MAX        23        highest hour value (BCD pair), wraps to 00
//  TIMEOUT_CYCLES  1000000   idle cycles in an edit state before auto-abort (>=2)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  setTime      in   1  1-cycle pulse: enter edit / advance field / commit
//  cancel       in   1  1-cycle pulse: abort edit, no load
//  inc, dec     in   1  1-cycle pulses: step selected field +1 / -1
//  cur_hr1..cur_sec0 in 4 each  live BCD time from watch (hr1,hr0,min1,min0,sec1,sec0)
//  hr1..sec0    out  4 each  edited BCD time; valid when load=1
//  load         out  1  1-cycle strobe: watch must take hr1..sec0
//  hold         out  1  1 while editing; watch counters stop
//  field        out  2  00 none, 01 hours, 10 minutes, 11 seconds (for blink)
// BEHAVIOUR
//  Reset: state IDLE; all digit outputs 0; load=0; hold=0; field=00; timer=0.
//  States: IDLE -> EDIT_HR -> EDIT_MIN -> EDIT_SEC -> COMMIT -> IDLE.
//  IDLE: setTime -> capture cur_* into shadow digits same edge, go EDIT_HR; inc/dec/cancel ignored.
//  EDIT_x: hold=1, field per state. setTime -> next state (EDIT_SEC -> COMMIT).
//   inc -> field+1: units 9->0 carries tens; MIN/SEC 59->00; HR HOUR_MAX->00.
//   dec -> field-1: units 0->9 borrows tens; 00 -> 59 (MIN/SEC) or HOUR_MAX (HR).
//   Result visible on outputs the cycle after the pulse; one step per pulse.
//  Priority in one cycle: cancel > setTime > inc/dec; inc&dec together = no change.
//  cancel in any EDIT_x -> IDLE next cycle, hold=0, no load, shadow digits retained.
//  Timeout: timer clears on any input pulse or state change; reaching TIMEOUT_CYCLES-1
//   in an EDIT_x acts exactly as cancel.
//  COMMIT: exactly one cycle, load=1, hold=1, digits stable; then IDLE, hold=0.
//   Inputs during COMMIT ignored; setTime is honoured again from IDLE next cycle.
//  Reset asserted mid-edit: immediate return to reset values, no load emitted.
//  Digits always legal BCD within range; a snapshot with hours > HOUR_MAX is clamped to 00.
// STRUCTURE
//  Shared include WatchDefs.vh: state encodings, field codes, BCD max constants (5,9,59).
//  Sub-module bcd_pair_stepper(tens, units, inc, dec, max_tens, max_units) ->
//   next tens/units with wrap; combinational, one instance muxed on selected field.
//  Top: FSM, shadow digit regs, timeout counter, load/hold generation.
// TESTING
//  Snapshot: cur=12:34:56, setTime -> next cycle hold=1, field=01, outputs 12:34:56.
//  Wrap: EDIT_HR at 23, inc -> 00; dec -> 23; EDIT_MIN at 00, dec -> 59; 09 inc -> 10.
//  Full pass: setTime x4 with one inc per field from 12:34:56 -> single load pulse, 13:35:57.
//  Cancel in EDIT_MIN -> hold=0 next cycle, load never asserted; inc in IDLE -> no change.
//  Priority: cancel+setTime same cycle -> IDLE; inc+dec same cycle -> value unchanged.
//  Timeout (TIMEOUT_CYCLES=8) idle in EDIT_SEC -> IDLE after 8 cycles; async reset mid-edit -> all 0.

Source files
------------

// File: rtl/watch_time_setter_pkg.sv
// Shared types and constants for the watch time-setting controller.
package watch_time_setter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEditHr,
    StEditMin,
    StEditSec,
    StCommit
  } state_e;

  localparam logic [1:0] FieldNone = 2'b00;
  localparam logic [1:0] FieldHr   = 2'b01;
  localparam logic [1:0] FieldMin  = 2'b10;
  localparam logic [1:0] FieldSec  = 2'b11;

  localparam logic [3:0] BcdMaxUnits   = 4'd9;
  localparam logic [3:0] MinSecMaxTens = 4'd5;

  // True when tens:units is legal BCD and does not exceed max_tens:max_units.
  function automatic logic bcd_in_range(input logic [3:0] tens, input logic [3:0] units,
                                        input logic [3:0] max_tens,
                                        input logic [3:0] max_units);
    if (tens > 4'd9 || units > 4'd9) return 1'b0;
    if (tens < max_tens) return 1'b1;
    return (tens == max_tens) && (units <= max_units);
  endfunction

endpackage

// File: rtl/watch_time_setter_bcd_pair_stepper.sv
// Combinational +1/-1 on a two-digit BCD value that wraps between 00 and a maximum.
module watch_time_setter_bcd_pair_stepper (
  input  logic [3:0] i_tens,
  input  logic [3:0] i_units,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic [3:0] i_max_tens,
  input  logic [3:0] i_max_units,
  output logic [3:0] o_tens,
  output logic [3:0] o_units
);

  always_comb begin
    o_tens  = i_tens;
    o_units = i_units;
    if (i_inc && !i_dec) begin
      if (i_tens == i_max_tens && i_units == i_max_units) begin
        o_tens  = 4'd0;
        o_units = 4'd0;
      end else if (i_units == 4'd9) begin
        o_tens  = i_tens + 4'd1;
        o_units = 4'd0;
      end else begin
        o_units = i_units + 4'd1;
      end
    end else if (i_dec && !i_inc) begin
      if (i_tens == 4'd0 && i_units == 4'd0) begin
        o_tens  = i_max_tens;
        o_units = i_max_units;
      end else if (i_units == 4'd0) begin
        o_tens  = i_tens - 4'd1;
        o_units = 4'd9;
      end else begin
        o_units = i_units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/watch_time_setter.sv
// Time-setting controller: snapshots the running time, lets the user step each field,
// and commits the edited digits to the watch with a one-cycle load strobe.
module watch_time_setter
  import watch_time_setter_pkg::*;
#(
  parameter int unsigned HOUR_MAX       = 23,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       setTime,
  input  logic       cancel,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] cur_hr1,
  input  logic [3:0] cur_hr0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  input  logic [3:0] cur_sec1,
  input  logic [3:0] cur_sec0,
  output logic [3:0] hr1,
  output logic [3:0] hr0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       load,
  output logic       hold,
  output logic [1:0] field
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] HrMaxTens  = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HrMaxUnits = 4'(HOUR_MAX % 10);

  state_e            r_state, w_state_d;
  logic [TimerW-1:0] r_timer, w_timer_d;
  logic [3:0]        r_hr1, r_hr0, r_min1, r_min0, r_sec1, r_sec0;
  logic [3:0]        w_hr1_d, w_hr0_d, w_min1_d, w_min0_d, w_sec1_d, w_sec0_d;
  logic [3:0]        w_sel_tens, w_sel_units, w_max_tens, w_max_units;
  logic [3:0]        w_step_tens, w_step_units;
  logic              w_edit, w_pulse, w_abort, w_step;

  always_comb begin
    w_sel_tens  = r_hr1;
    w_sel_units = r_hr0;
    w_max_tens  = HrMaxTens;
    w_max_units = HrMaxUnits;
    unique case (r_state)
      StEditMin: begin
        w_sel_tens  = r_min1;
        w_sel_units = r_min0;
        w_max_tens  = MinSecMaxTens;
        w_max_units = BcdMaxUnits;
      end
      StEditSec: begin
        w_sel_tens  = r_sec1;
        w_sel_units = r_sec0;
        w_max_tens  = MinSecMaxTens;
        w_max_units = BcdMaxUnits;
      end
      default: ;
    endcase
  end

  watch_time_setter_bcd_pair_stepper u_stepper (
    .i_tens      (w_sel_tens),
    .i_units     (w_sel_units),
    .i_inc       (inc),
    .i_dec       (dec),
    .i_max_tens  (w_max_tens),
    .i_max_units (w_max_units),
    .o_tens      (w_step_tens),
    .o_units     (w_step_units)
  );

  always_comb begin
    w_edit  = (r_state == StEditHr) || (r_state == StEditMin) || (r_state == StEditSec);
    w_pulse = setTime || cancel || inc || dec;
    // Timeout behaves exactly like a cancel pulse.
    w_abort = w_edit && (cancel || (r_timer == TimerLast));
    w_step  = w_edit && !w_abort && !setTime;

    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (setTime) w_state_d = StEditHr;
      StEditHr:  if (w_abort) w_state_d = StIdle; else if (setTime) w_state_d = StEditMin;
      StEditMin: if (w_abort) w_state_d = StIdle; else if (setTime) w_state_d = StEditSec;
      StEditSec: if (w_abort) w_state_d = StIdle; else if (setTime) w_state_d = StCommit;
      StCommit:  w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase

    if (!w_edit || w_pulse || (w_state_d != r_state)) w_timer_d = '0;
    else w_timer_d = r_timer + 1'b1;

    w_hr1_d  = r_hr1;
    w_hr0_d  = r_hr0;
    w_min1_d = r_min1;
    w_min0_d = r_min0;
    w_sec1_d = r_sec1;
    w_sec0_d = r_sec0;
    if (r_state == StIdle && setTime) begin
      // Illegal or out-of-range snapshot pairs are clamped to 00.
      if (bcd_in_range(cur_hr1, cur_hr0, HrMaxTens, HrMaxUnits)) begin
        w_hr1_d = cur_hr1;
        w_hr0_d = cur_hr0;
      end else begin
        w_hr1_d = 4'd0;
        w_hr0_d = 4'd0;
      end
      if (bcd_in_range(cur_min1, cur_min0, MinSecMaxTens, BcdMaxUnits)) begin
        w_min1_d = cur_min1;
        w_min0_d = cur_min0;
      end else begin
        w_min1_d = 4'd0;
        w_min0_d = 4'd0;
      end
      if (bcd_in_range(cur_sec1, cur_sec0, MinSecMaxTens, BcdMaxUnits)) begin
        w_sec1_d = cur_sec1;
        w_sec0_d = cur_sec0;
      end else begin
        w_sec1_d = 4'd0;
        w_sec0_d = 4'd0;
      end
    end else if (w_step) begin
      unique case (r_state)
        StEditHr:  begin w_hr1_d  = w_step_tens; w_hr0_d  = w_step_units; end
        StEditMin: begin w_min1_d = w_step_tens; w_min0_d = w_step_units; end
        StEditSec: begin w_sec1_d = w_step_tens; w_sec0_d = w_step_units; end
        default: ;
      endcase
    end

    load  = (r_state == StCommit);
    hold  = w_edit || (r_state == StCommit);
    field = FieldNone;
    unique case (r_state)
      StEditHr:  field = FieldHr;
      StEditMin: field = FieldMin;
      StEditSec: field = FieldSec;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_hr1   <= 4'd0;
      r_hr0   <= 4'd0;
      r_min1  <= 4'd0;
      r_min0  <= 4'd0;
      r_sec1  <= 4'd0;
      r_sec0  <= 4'd0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_hr1   <= w_hr1_d;
      r_hr0   <= w_hr0_d;
      r_min1  <= w_min1_d;
      r_min0  <= w_min0_d;
      r_sec1  <= w_sec1_d;
      r_sec0  <= w_sec0_d;
    end
  end

  assign hr1  = r_hr1;
  assign hr0  = r_hr0;
  assign min1 = r_min1;
  assign min0 = r_min0;
  assign sec1 = r_sec1;
  assign sec0 = r_sec0;

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed bench for watch_time_setter: snapshot, stepping, wrap, commit, cancel, timeout.
module tb_watch_time_setter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       setTime = 1'b0, cancel = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [3:0] cur_hr1 = 4'd0, cur_hr0 = 4'd0, cur_min1 = 4'd0;
  logic [3:0] cur_min0 = 4'd0, cur_sec1 = 4'd0, cur_sec0 = 4'd0;
  logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
  logic       load, hold;
  logic [1:0] field;

  int n_checks = 0;
  int n_fail   = 0;
  int load_cnt = 0;

  logic [23:0] w_time;
  logic [3:0]  w_ctl;
  assign w_time = {hr1, hr0, min1, min0, sec1, sec0};
  assign w_ctl  = {load, hold, field};

  watch_time_setter #(
    .HOUR_MAX       (23),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .setTime  (setTime),
    .cancel   (cancel),
    .inc      (inc),
    .dec      (dec),
    .cur_hr1  (cur_hr1),
    .cur_hr0  (cur_hr0),
    .cur_min1 (cur_min1),
    .cur_min0 (cur_min0),
    .cur_sec1 (cur_sec1),
    .cur_sec0 (cur_sec0),
    .hr1      (hr1),
    .hr0      (hr0),
    .min1     (min1),
    .min0     (min0),
    .sec1     (sec1),
    .sec0     (sec0),
    .load     (load),
    .hold     (hold),
    .field    (field)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the selected inputs {setTime, cancel, inc, dec}.
  task automatic press(input logic [3:0] p);
    {setTime, cancel, inc, dec} = p;
    tick();
    {setTime, cancel, inc, dec} = 4'b0000;
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_hr1, cur_hr0, cur_min1, cur_min0, cur_sec1, cur_sec0} = t;
  endtask

  task automatic chk_time(input string tag, input logic [23:0] exp);
    n_checks++;
    assert (w_time === exp) else begin
      n_fail++;
      $error("FAIL %s: observed time %h expected %h", tag, w_time, exp);
    end
  endtask

  // exp = {load, hold, field}
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    n_checks++;
    assert (w_ctl === exp) else begin
      n_fail++;
      $error("FAIL %s: observed load/hold/field %b expected %b", tag, w_ctl, exp);
    end
  endtask

  task automatic chk_loads(input string tag, input int exp);
    n_checks++;
    assert (load_cnt === exp) else begin
      n_fail++;
      $error("FAIL %s: observed load pulses %0d expected %0d", tag, load_cnt, exp);
    end
  endtask

  localparam logic [3:0] PSet = 4'b1000, PCan = 4'b0100, PInc = 4'b0010, PDec = 4'b0001;

  initial begin
    set_cur(24'h123456);
    tick();
    tick();
    chk_time("reset_time", 24'h000000);
    chk_ctl("reset_ctl", 4'b0000);
    reset = 1'b1;
    tick();

    // Snapshot and full commit pass
    press(PSet);
    chk_time("snapshot_time", 24'h123456);
    chk_ctl("snapshot_ctl", 4'b0101);
    press(PInc);
    chk_time("hr_inc", 24'h133456);
    press(PSet);
    chk_ctl("field_min", 4'b0110);
    press(PInc);
    chk_time("min_inc", 24'h133556);
    press(PSet);
    chk_ctl("field_sec", 4'b0111);
    press(PInc);
    chk_time("sec_inc", 24'h133557);
    chk_loads("no_load_before_commit", 0);
    press(PSet);
    chk_ctl("commit_ctl", 4'b1100);
    chk_time("commit_time", 24'h133557);
    press(PSet | PInc); // ignored while committing
    chk_ctl("after_commit_ctl", 4'b0000);
    chk_time("after_commit_time", 24'h133557);
    chk_loads("single_load", 1);
    press(PSet);
    chk_ctl("reenter_after_commit", 4'b0101);
    press(PCan);

    // Wrap-around on every field
    set_cur(24'h230009);
    press(PSet);
    chk_time("wrap_snapshot", 24'h230009);
    press(PInc);
    chk_time("hr_23_inc", 24'h000009);
    press(PDec);
    chk_time("hr_00_dec", 24'h230009);
    press(PSet);
    press(PDec);
    chk_time("min_00_dec", 24'h235909);
    press(PInc);
    chk_time("min_59_inc", 24'h230009);
    press(PSet);
    press(PInc);
    chk_time("sec_09_inc", 24'h230010);
    press(PDec);
    chk_time("sec_10_dec", 24'h230009);

    // Cancel in EDIT_MIN keeps shadow digits and never loads
    press(PCan);
    load_cnt = 0;
    set_cur(24'h010203);
    press(PSet);
    press(PSet);
    press(PInc);
    chk_time("cancel_pre", 24'h010303);
    press(PCan);
    chk_ctl("cancel_ctl", 4'b0000);
    chk_time("cancel_retained", 24'h010303);
    press(PInc);
    chk_time("idle_inc_ignored", 24'h010303);
    chk_ctl("idle_inc_ctl", 4'b0000);
    chk_loads("cancel_no_load", 0);

    // Priority
    press(PSet);
    press(PCan | PSet);
    chk_ctl("cancel_beats_set", 4'b0000);
    press(PSet);
    press(PInc | PDec);
    chk_time("inc_dec_together", 24'h010203);
    chk_ctl("inc_dec_ctl", 4'b0101);
    press(PCan | PInc);
    chk_time("cancel_beats_inc", 24'h010203);
    chk_ctl("cancel_beats_inc_ctl", 4'b0000);

    // Out-of-range hour snapshot is clamped
    set_cur(24'h254512);
    press(PSet);
    chk_time("hour_clamp", 24'h004512);

    // Timeout: idle 8 cycles in EDIT_SEC aborts like cancel
    press(PSet);
    press(PSet);
    for (int i = 0; i < 7; i++) tick();
    chk_ctl("timeout_cycle7", 4'b0111);
    tick();
    chk_ctl("timeout_cycle8", 4'b0000);
    chk_time("timeout_retained", 24'h004512);
    chk_loads("timeout_no_load", 0);

    // Asynchronous reset mid-edit
    set_cur(24'h123456);
    press(PSet);
    press(PInc);
    chk_time("pre_reset", 24'h133456);
    #2;
    reset = 1'b0;
    #1;
    chk_time("async_reset_time", 24'h000000);
    chk_ctl("async_reset_ctl", 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    chk_loads("reset_no_load", 0);
    press(PSet);
    chk_time("post_reset_snapshot", 24'h123456);
    chk_ctl("post_reset_ctl", 4'b0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
